// File: rtl/wb_uart_fifo.sv
// rtl/wb_uart_fifo.sv - Wishbone UART with TX/RX FIFOs, baud divisor, interrupts; optional UART_LOOPBACK_EN
module wb_uart_fifo_buf #(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [7:0]             wdata,
   output logic [7:0]             rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a full FIFO still accepts a push when a pop retires an entry in the same cycle
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push & ~do_pop)      count <= count + CNT_ONE;
         else if (do_pop & ~do_push) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

module wb_uart_fifo #(
   parameter logic [31:0]      BASE_ADDR  = 32'h3000_0000,
   parameter int               FIFO_DEPTH = 16,
   parameter int               DIV_W      = 16,
   parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(433)
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic [2:0]  irq_o
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(3);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

   logic             access, wr, rd;
   logic [5:0]       offset;
   logic [31:0]      rdata, ctrl_cur;
   logic [DIV_W-1:0] div, div_mask, div_new;
   logic [2:0]       ien, err_clr;
   logic             rxovr, frame_err, txovf;
   logic             unused_bits;

   logic             tx_push, tx_pop, tx_empty, tx_full, tx_busy, tx_bit, tx_line;
   logic [7:0]       tx_head, tx_shift;
   logic [CW-1:0]    tx_count;
   tx_state_t        tx_state, tx_next;
   logic [DIV_W-1:0] tx_cnt, tx_div;
   logic [2:0]       tx_idx;
   logic             tx_bit_end;

   logic             rx_push, rx_pop, rx_empty, rx_full, rx_in, rx_s, rx_prev;
   logic [1:0]       rx_sync;
   logic [7:0]       rx_head, rx_shift;
   logic [CW-1:0]    rx_count;
   rx_state_t        rx_state, rx_next;
   logic [DIV_W-1:0] rx_cnt, rx_div;
   logic [DIV_W:0]   rx_half;
   logic [2:0]       rx_idx;
   logic             rx_tick, rx_half_tick, rx_sample, frame_set;

   assign access = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
   assign wr      = access & wbs_we_i;
   assign rd      = access & ~wbs_we_i;
   assign offset  = wbs_adr_i[7:2];
   assign rx_pop  = rd & (offset == 6'd0);
   assign tx_push = wr & (offset == 6'd1) & wbs_sel_i[0];
   assign err_clr = (wr && offset == 6'd2 && wbs_sel_i[1]) ? wbs_dat_i[10:8] : 3'b000;
   assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i, tx_count};

`ifdef UART_LOOPBACK_EN
   logic loop_en;
   assign ctrl_cur  = {loop_en, 31'(div)};
   assign rx_in     = loop_en ? tx_line : uart_rx_i;
   assign uart_tx_o = loop_en ? 1'b1 : tx_line;
`else
   assign ctrl_cur  = 32'(div);
   assign rx_in     = uart_rx_i;
   assign uart_tx_o = tx_line;
`endif

   always_comb begin
      for (int i = 0; i < DIV_W; i++) div_mask[i] = wbs_sel_i[i/8];
      div_new = (wbs_dat_i[DIV_W-1:0] & div_mask) | (div & ~div_mask);
   end

   always_comb begin
      rdata = '0;
      case (offset)
         6'd0: if (!rx_empty) rdata = {23'd0, 1'b1, rx_head};
         6'd2: rdata = {16'(rx_count), 5'd0, txovf, frame_err, rxovr,
                        3'd0, tx_busy, tx_full, tx_empty, rx_full, rx_empty};
         6'd3: rdata = ctrl_cur;
         6'd4: rdata = {29'd0, ien};
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         div       <= DIV_RESET;
         ien       <= '0;
         rxovr     <= 1'b0;
         frame_err <= 1'b0;
         txovf     <= 1'b0;
         irq_o     <= '0;
`ifdef UART_LOOPBACK_EN
         loop_en   <= 1'b0;
`endif
      end else begin
         wbs_ack_o <= access;
         wbs_dat_o <= rd ? rdata : '0;
         if (wr && offset == 6'd3) div <= (div_new < DIV_MIN) ? DIV_MIN : div_new;
`ifdef UART_LOOPBACK_EN
         if (wr && offset == 6'd3 && wbs_sel_i[3]) loop_en <= wbs_dat_i[31];
`endif
         if (wr && offset == 6'd4 && wbs_sel_i[0]) ien <= wbs_dat_i[2:0];
         rxovr     <= (rxovr & ~err_clr[0]) | (rx_push & rx_full & ~rx_pop);
         frame_err <= (frame_err & ~err_clr[1]) | frame_set;
         txovf     <= (txovf & ~err_clr[2]) | (tx_push & tx_full & ~tx_pop);
         irq_o     <= {ien[2] & (rxovr | frame_err | txovf),
                       ien[1] & tx_empty & ~tx_busy,
                       ien[0] & ~rx_empty};
      end
   end

   wb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_push), .pop(tx_pop), .wdata(wbs_dat_i[7:0]),
      .rdata(tx_head), .count(tx_count), .empty(tx_empty), .full(tx_full));

   wb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .pop(rx_pop), .wdata(rx_shift),
      .rdata(rx_head), .count(rx_count), .empty(rx_empty), .full(rx_full));

   assign tx_bit_end = (tx_cnt == tx_div);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) tx_state <= TX_IDLE;
      else          tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (!tx_empty) tx_next = TX_START;
         TX_START: if (tx_bit_end) tx_next = TX_DATA;
         TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_bit_end) tx_next = tx_empty ? TX_IDLE : TX_START;
         default:  tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_busy = (tx_state != TX_IDLE);
      tx_pop  = ~tx_empty & ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));
      case (tx_state)
         TX_START: tx_bit = 1'b0;
         TX_DATA:  tx_bit = tx_shift[0];
         default:  tx_bit = 1'b1;
      endcase
   end

   // the divisor is only re-latched at bit boundaries so a frame keeps its rate
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tx_cnt   <= '0;
         tx_div   <= DIV_RESET;
         tx_shift <= '0;
         tx_idx   <= '0;
         tx_line  <= 1'b1;
      end else begin
         if (tx_state == TX_IDLE || tx_bit_end) begin
            tx_cnt <= '0;
            tx_div <= div;
         end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
         end
         if (tx_pop) tx_shift <= tx_head;
         else if (tx_state == TX_DATA && tx_bit_end) tx_shift <= tx_shift >> 1;
         if (tx_state == TX_START) tx_idx <= '0;
         else if (tx_state == TX_DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
         tx_line <= tx_bit;
      end
   end

   assign rx_s         = rx_sync[1];
   assign rx_half      = ({1'b0, rx_div} + (DIV_W+1)'(1)) >> 1;
   assign rx_half_tick = ({1'b0, rx_cnt} == rx_half);
   assign rx_tick      = (rx_cnt == rx_div);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) rx_state <= RX_IDLE;
      else          rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
         RX_START: if (rx_half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_WAIT;
         RX_WAIT:  if (rx_s) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_sample = (rx_state == RX_DATA) & rx_tick;
      rx_push   = (rx_state == RX_STOP) & rx_tick & rx_s;
      frame_set = (rx_state == RX_STOP) & rx_tick & ~rx_s;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_cnt   <= '0;
         rx_div   <= DIV_RESET;
         rx_shift <= '0;
         rx_idx   <= '0;
      end else begin
         rx_sync <= {rx_sync[0], rx_in};
         rx_prev <= rx_s;
         if (rx_state != rx_next || rx_sample) begin
            rx_cnt <= '0;
            rx_div <= div;
         end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
         end
         if (rx_state == RX_START) rx_idx <= '0;
         else if (rx_sample) rx_idx <= rx_idx + 3'd1;
         if (rx_sample) rx_shift <= {rx_s, rx_shift[7:1]};
      end
   end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// tb/tb_wb_uart_fifo.sv - directed self-checking bench for wb_uart_fifo
module tb_wb_uart_fifo;
   localparam int DEPTH = 4;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0, rst;
   logic        cyc, stb, we, ack, rx, tx;
   logic [3:0]  sel;
   logic [31:0] adr, wdat, dat_o;
   logic [2:0]  irq;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   wb_uart_fifo #(.FIFO_DEPTH(DEPTH)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .uart_rx_i(rx), .uart_tx_o(tx), .irq_o(irq));

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] q, output logic acked);
      @(negedge clk);
      cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
      acked = 0; q = '0;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(negedge clk);
         if (ack) begin acked = 1; q = dat_o; end
      end
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] q; logic ok;
      bus(1'b1, BASE | 32'(off), d, s, q, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL write_ack off=%h: no ack, required ack", off); end
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] q);
      logic ok;
      bus(1'b0, BASE | 32'(off), 32'd0, 4'hF, q, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL read_ack off=%h: no ack, required ack", off); end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      @(negedge clk); rx = 0; repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (8) @(negedge clk); end
      rx = stop_bit; repeat (8) @(negedge clk);
      rx = 1; repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] q;
      rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; rx = 1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
      if (irq !== 3'b000) begin errors++; $display("FAIL reset_irq: got %b required 000", irq); end
      if (ack !== 1'b0)   begin errors++; $display("FAIL reset_ack: got %b required 0", ack); end
      if (dat_o !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h required 0", dat_o); end
      rst = 0;
      rd(8'h08, q); checks++;
      if (q !== 32'h5) begin errors++; $display("FAIL reset_status: got %h required 00000005", q); end
      rd(8'h0C, q); checks++;
      if (q !== 32'd433) begin errors++; $display("FAIL reset_div: got %0d required 433", q); end
   endtask

   task automatic test_ctrl();
      logic [31:0] q; logic [31:0] d; logic ok;
      wr(8'h0C, 32'h0, 4'hF); rd(8'h0C, q); checks++;
      if (q !== 32'd3) begin errors++; $display("FAIL div_clamp: got %h required 3", q); end
      wr(8'h0C, 32'h7, 4'hF); wr(8'h0C, 32'h0000_AB00, 4'b0010); rd(8'h0C, q); checks++;
      if (q !== 32'hAB07) begin errors++; $display("FAIL div_bytesel: got %h required ab07", q); end
      wr(8'h0C, 32'h7, 4'hF);
      rd(8'h20, q); checks++;
      if (q !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h required 0", q); end
      bus(1'b0, BASE + 32'h100, 32'd0, 4'hF, d, ok); checks++;
      if (ok !== 1'b0) begin errors++; $display("FAIL out_of_window: got ack %b required 0", ok); end
`ifndef UART_LOOPBACK_EN
      wr(8'h0C, 32'h8000_0007, 4'hF); rd(8'h0C, q); checks++;
      if (q !== 32'h7) begin errors++; $display("FAIL ctrl31_ignored: got %h required 7", q); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [3:0] pat;
      @(negedge clk); cyc = 1; stb = 1; we = 0; adr = BASE | 32'h8;
      for (int i = 0; i < 4; i++) begin @(negedge clk); pat[3-i] = ack; end
      cyc = 0; stb = 0; checks++;
      if (pat !== 4'b1010) begin errors++; $display("FAIL ack_pattern: got %b required 1010", pat); end
   endtask

   task automatic test_tx();
      logic txs [91]; logic irqs [91]; logic found; int low, rise;
      logic [9:0] exp_bits;
      exp_bits = 10'b1_1010_0101_0;
      wr(8'h10, 32'h2, 4'hF); @(negedge clk); checks++;
      if (irq[1] !== 1'b1) begin errors++; $display("FAIL irq_tx_idle: got %b required 1", irq[1]); end
      wr(8'h04, 32'hA5, 4'h1);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin if (tx == 0) found = 1; else @(negedge clk); end
      checks++;
      if (!found) begin errors++; $display("FAIL tx_start_timeout: no start bit, required one"); end
      for (int i = 0; i < 91; i++) begin txs[i] = tx; irqs[i] = irq[1]; @(negedge clk); end
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (txs[8*k+4] !== exp_bits[k]) begin
            errors++; $display("FAIL tx_bit%0d: got %b required %b", k, txs[8*k+4], exp_bits[k]);
         end
      end
      low = 0; while (low < 91 && txs[low] == 0) low++;
      checks++;
      if (low != 8) begin errors++; $display("FAIL tx_bit_len: got %0d required 8", low); end
      rise = 0; while (rise < 90 && irqs[rise] != 1) rise++;
      checks++;
      if (rise != 80) begin errors++; $display("FAIL tx_busy_len: got %0d required 80", rise); end
      wr(8'h10, 32'h0, 4'hF);
   endtask

   task automatic test_rx();
      logic [31:0] q;
      wr(8'h10, 32'h1, 4'hF);
      send_rx(8'h3C, 1'b1); checks++;
      if (irq[0] !== 1'b1) begin errors++; $display("FAIL irq_rx_set: got %b required 1", irq[0]); end
      rd(8'h00, q); checks++;
      if (q !== 32'h13C) begin errors++; $display("FAIL rx_data: got %h required 13c", q); end
      rd(8'h00, q); checks++;
      if (q !== 32'h0) begin errors++; $display("FAIL rx_empty_read: got %h required 0", q); end
      repeat (2) @(negedge clk); checks++;
      if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_rx_clear: got %b required 0", irq[0]); end
      rd(8'h08, q); checks++;
      if (q !== 32'h5) begin errors++; $display("FAIL rx_status: got %h required 5", q); end
   endtask

   task automatic test_frame_error();
      logic [31:0] q;
      wr(8'h10, 32'h4, 4'hF);
      send_rx(8'h81, 1'b0);
      rd(8'h08, q); checks++;
      if (q !== 32'h205) begin errors++; $display("FAIL frame_status: got %h required 205", q); end
      checks++;
      if (irq[2] !== 1'b1) begin errors++; $display("FAIL irq_err_set: got %b required 1", irq[2]); end
      wr(8'h08, 32'h200, 4'b0010); rd(8'h08, q); checks++;
      if (q !== 32'h5) begin errors++; $display("FAIL frame_clear: got %h required 5", q); end
      @(negedge clk); checks++;
      if (irq[2] !== 1'b0) begin errors++; $display("FAIL irq_err_clear: got %b required 0", irq[2]); end
   endtask

   task automatic test_rx_overrun();
      logic [31:0] q;
      for (int i = 0; i < DEPTH + 1; i++) send_rx(8'h10 + 8'(i), 1'b1);
      rd(8'h08, q); checks++;
      if (q !== 32'h0004_0106) begin errors++; $display("FAIL rx_overrun_status: got %h required 00040106", q); end
      for (int i = 0; i < DEPTH; i++) begin
         rd(8'h00, q); checks++;
         if (q !== 32'h110 + 32'(i)) begin
            errors++; $display("FAIL rx_fifo_order%0d: got %h required %h", i, q, 32'h110 + 32'(i));
         end
      end
      wr(8'h08, 32'h100, 4'b0010);
   endtask

   task automatic test_tx_overflow();
      logic [7:0] exp_tx [5]; int nframes;
      exp_tx = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      nframes = 0;
      wr(8'h0C, 32'd63, 4'hF);
      fork
         begin
            logic [31:0] q;
            for (int i = 0; i < DEPTH + 2; i++) wr(8'h04, 32'h11 + 32'(i), 4'h1);
            rd(8'h08, q); checks++;
            if (q[10] !== 1'b1) begin errors++; $display("FAIL txovf_set: got %b required 1", q[10]); end
            wr(8'h08, 32'h400, 4'b0010); rd(8'h08, q); checks++;
            if (q[10] !== 1'b0) begin errors++; $display("FAIL txovf_clear: got %b required 0", q[10]); end
         end
         begin
            logic found; logic [7:0] b; logic stop_v;
            for (int f = 0; f < 7; f++) begin
               found = 0;
               for (int i = 0; i < 200 && !found; i++) begin @(negedge clk); if (tx == 0) found = 1; end
               if (!found) break;
               nframes++;
               repeat (32) @(negedge clk);
               for (int k = 0; k < 8; k++) begin repeat (64) @(negedge clk); b[k] = tx; end
               repeat (64) @(negedge clk); stop_v = tx;
               if (f < 5) begin
                  checks++;
                  if (b !== exp_tx[f] || stop_v !== 1'b1) begin
                     errors++; $display("FAIL tx_frame%0d: got %h stop %b required %h stop 1", f, b, stop_v, exp_tx[f]);
                  end
               end
            end
         end
      join
      checks++;
      if (nframes != DEPTH + 1) begin errors++; $display("FAIL tx_frame_count: got %0d required %0d", nframes, DEPTH + 1); end
   endtask

`ifdef UART_LOOPBACK_EN
   task automatic test_loopback();
      logic [31:0] q; int lows;
      lows = 0;
      wr(8'h0C, 32'h8000_0007, 4'hF); wr(8'h04, 32'h55, 4'h1);
      for (int i = 0; i < 120; i++) begin @(negedge clk); if (tx == 0) lows++; end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL loop_tx_held: got %0d low cycles required 0", lows); end
      rd(8'h00, q); checks++;
      if (q !== 32'h155) begin errors++; $display("FAIL loop_rxdata: got %h required 155", q); end
      wr(8'h0C, 32'h7, 4'hF);
   endtask
`endif

   task automatic test_reset_midframe();
      logic [31:0] q; logic found;
      wr(8'h0C, 32'h7, 4'hF); wr(8'h04, 32'h00, 4'h1);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (tx == 0) found = 1; end
      rx = 0; repeat (20) @(negedge clk);
      #2 rst = 1; #1; checks++;
      if (tx !== 1'b1 || !found) begin errors++; $display("FAIL reset_midframe_tx: got %b found %b required 1 1", tx, found); end
      @(negedge clk); rst = 0; rx = 1;
      repeat (100) @(negedge clk);
      rd(8'h08, q); checks++;
      if (q !== 32'h5) begin errors++; $display("FAIL reset_midframe_status: got %h required 5", q); end
      rd(8'h0C, q); checks++;
      if (q !== 32'd433) begin errors++; $display("FAIL reset_midframe_div: got %0d required 433", q); end
   endtask

   initial begin
      test_reset();
      test_ctrl();
      test_back_to_back();
      test_tx();
      test_rx();
      test_frame_error();
      test_rx_overrun();
      test_tx_overflow();
`ifdef UART_LOOPBACK_EN
      test_loopback();
`endif
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_uart_fifo.md
Name: wb_uart_fifo

Overview:
Parametrised Wishbone-slave UART with separate TX and RX FIFOs, a programmable baud divisor and three maskable interrupts. It is the next generation of the single-buffer UART attached to the management SoC Wishbone bus, and it is instantiated inside the user project wrapper. Its serial pins are mapped onto io_in/io_out by the wrapper.

Parameters:
BASE_ADDR, 32'h3000_0000, register window base; decode uses adr[31:8].
FIFO_DEPTH, 16, entries per FIFO; power of 2, minimum 2.
DIV_W, 16, width of the baud divisor.
DIV_RESET, 16'd433, divisor value after reset.

Ports:
wb_clk_i  in  1  sole clock.
wb_rst_i  in  1  asynchronous reset, active-high.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_stb_i  in  1  Wishbone strobe.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte selects; bytes with sel=0 are not written.
wbs_adr_i  in  32  byte address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
uart_rx_i  in  1  serial input; asynchronous.
uart_tx_o  out  1  serial output.
irq_o  out  3  [0] RX data available, [1] TX FIFO empty, [2] error.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, uart_tx_o=1, irq_o=0. Both FIFOs are emptied, error flags are cleared, all interrupt enables are 0, and DIV=DIV_RESET.
- Bus: a request is cyc&stb&(adr[31:8]==BASE_ADDR[31:8]).
  - ack is asserted for exactly 1 cycle, one cycle after the request is seen.
  - ack is held low in the cycle following an ack, so each access costs 2 cycles minimum.
  - Out-of-window addresses receive no ack.
  - Unmapped in-window offsets are acked, read as 0, and ignore writes.
- Registers (adr[7:2]):
  - 0x00 RXDATA (read-only): [7:0]=head byte, [8]=valid. A read pops the FIFO only if it is non-empty. A read of an empty FIFO returns 0 and pops nothing.
  - 0x04 TXDATA (write-only): sel[0] write pushes [7:0]. A push to a full FIFO is dropped and sets TXOVF.
  - 0x08 STATUS: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_busy, [8] RXOVR, [9] FRAME, [10] TXOVF.
    - Error bits are sticky; writing 1 to a bit clears it.
    - [31:16] is the RX occupancy count, range 0..FIFO_DEPTH.
  - 0x0C CTRL: [DIV_W-1:0]=DIV, byte-selectable. Bit period = DIV+1 clocks. Writes of DIV<3 are clamped to 3.
  - 0x10 IEN: [2:0] interrupt enables.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: leaves IDLE when the TX FIFO is non-empty; the byte is popped on entry to START.
  - START: drives 0 for 1 bit.
  - DATA: 8 bits, LSB first.
  - STOP: drives 1 for 1 bit.
  - Back-to-back bytes have no idle gap between them.
  - tx_busy=1 in every state except IDLE.
- RX:
  - uart_rx_i passes through a 2-flop synchroniser.
  - IDLE: a falling edge moves to START.
  - START: resamples at (DIV+1)/2 clocks. If the sample is 1 (glitch), return to IDLE.
  - DATA: 8 samples, each at bit centre.
  - STOP: sample at bit centre.
    - Stop=1: push the byte. If the RX FIFO is full, the byte is dropped and RXOVR is set.
    - Stop=0: the byte is dropped, FRAME is set, and the FSM waits for line=1 before returning to IDLE.
- A DIV write takes effect at the next bit boundary of each FSM. A frame in progress completes at the old rate up to that boundary.
- Simultaneous push and pop on one FIFO: both happen and the count is unchanged. On a full FIFO, a simultaneous pop+push is accepted with no overflow. Pointers wrap modulo FIFO_DEPTH.
- irq_o is registered, one cycle after the condition:
  - [0] = IEN[0] & !rx_empty.
  - [1] = IEN[1] & tx_empty & !tx_busy.
  - [2] = IEN[2] & (RXOVR|FRAME|TXOVF).
- Reset asserted mid-frame: tx returns to 1 immediately, and the partial RX byte is discarded.

Optional Feature:
UART_LOOPBACK_EN
- Defined: CTRL[31] is a loopback bit. When CTRL[31]=1, the RX input is driven internally from the TX serial output, and uart_tx_o is held at 1.
- Not defined: CTRL[31] reads 0 and ignores writes; no loopback mux exists.

Test Plan:
- Reset, then read 0x08 → 0x0000_0005; read 0x0C → 433; uart_tx_o=1; irq_o=0.
- Write DIV=7, push 0xA5 → uart_tx_o shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1; each bit is 8 clocks; tx_busy drops after 80 clocks.
- Drive the 8N1 frame for 0x3C on uart_rx_i at DIV=7 with IEN=1 → irq_o[0]=1; 0x00 reads 0x13C; the next read of 0x00 returns 0x000 and irq_o[0]=0.
- Push FIFO_DEPTH+2 bytes within one bit time → STATUS[10]=1; exactly FIFO_DEPTH+1 frames are transmitted (one byte is already in the shifter). Write 1<<10 to 0x08 → the bit clears.
- Send an RX frame with stop=0 → FRAME=1 and no push. Send FIFO_DEPTH+1 valid frames without reading → RXOVR=1 and count=FIFO_DEPTH.
- (UART_LOOPBACK_EN) Set CTRL[31]=1, push 0x55 → RXDATA reads 0x155; uart_tx_o stays 1.
